// File: rtl/bht_predictor.sv
// Fetch-stage gshare direction predictor (2-bit counters) with a direct-mapped BTB.
// Lookup is combinational on if_pc; tables and global history update when a branch/jump resolves in EX.
module bht_predictor #(
  parameter int BHT_IDX   = 6,
  parameter int BTB_IDX   = 4,
  parameter int HIST_BITS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        if_pc,
  output logic               pred_taken,
  output logic [31:0]        pred_target,
  output logic [BHT_IDX-1:0] pred_idx,
  input  logic               ex_load,
  input  logic               ex_branch,
  input  logic               ex_jump,
  input  logic [31:0]        ex_pc,
  input  logic               ex_taken,
  input  logic [31:0]        ex_target,
  input  logic               ex_pred_taken,
  input  logic [31:0]        ex_pred_target,
  input  logic [BHT_IDX-1:0] ex_pred_idx,
  output logic               misprediction
);

  localparam int BHT_N = 1 << BHT_IDX;
  localparam int BTB_N = 1 << BTB_IDX;
  localparam int TAG_W = 30 - BTB_IDX;
  localparam int GW    = (HIST_BITS > 0) ? HIST_BITS : 1;

  logic [1:0]        ctr_reg        [BHT_N];
  logic              btb_valid_reg  [BTB_N];
  logic              btb_jump_reg   [BTB_N];
  logic [TAG_W-1:0]  btb_tag_reg    [BTB_N];
  logic [31:0]       btb_target_reg [BTB_N];
  logic [GW-1:0]     ghr_reg;
  logic [GW-1:0]     ghr_next;

  logic [BHT_IDX-1:0] hist_ext;
  logic [BHT_IDX-1:0] idx;
  logic [BTB_IDX-1:0] bslot;
  logic [BTB_IDX-1:0] ex_slot;
  logic               hit;
  logic               upd;
  logic               stale;
  logic [1:0]         ctr_cur;
  logic [1:0]         ctr_next;
  logic               unused_bits;

  // HIST_BITS=0 degenerates to a bimodal table indexed by PC alone.
  generate
    if (HIST_BITS == 0) begin : g_bimodal
      assign hist_ext = '0;
      assign ghr_next = '0;
    end else begin : g_gshare
      assign hist_ext = BHT_IDX'(ghr_reg);
      if (HIST_BITS == 1) begin : g_h1
        assign ghr_next = ex_taken;
      end else begin : g_hn
        assign ghr_next = {ghr_reg[GW-2:0], ex_taken};
      end
    end
  endgenerate

  assign unused_bits = ^{ex_pc[1:0], ghr_reg};

  // Lookup
  assign idx         = if_pc[BHT_IDX+1:2] ^ hist_ext;
  assign bslot       = if_pc[BTB_IDX+1:2];
  assign hit         = btb_valid_reg[bslot] && (btb_tag_reg[bslot] == if_pc[31:BTB_IDX+2]);
  assign pred_taken  = hit && (btb_jump_reg[bslot] || ctr_reg[idx][1]);
  assign pred_target = pred_taken ? btb_target_reg[bslot] : (if_pc + 32'd4);
  assign pred_idx    = idx;

  // Resolve; a non-control instruction that was predicted taken hit a stale BTB entry.
  assign upd     = ex_load && (ex_branch || ex_jump);
  assign stale   = ex_load && !ex_branch && !ex_jump && ex_pred_taken;
  assign ex_slot = ex_pc[BTB_IDX+1:2];
  assign misprediction = rst_n &&
                         ((upd && ((ex_taken != ex_pred_taken) ||
                                   (ex_taken && (ex_target != ex_pred_target)))) || stale);

  always_comb begin
    ctr_cur  = ctr_reg[ex_pred_idx];
    ctr_next = ctr_cur;
    if (ex_taken && ctr_cur != 2'b11) begin
      ctr_next = ctr_cur + 2'd1;
    end else if (!ex_taken && ctr_cur != 2'b00) begin
      ctr_next = ctr_cur - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_N; i++) begin
        ctr_reg[i] <= 2'b01;
      end
      ghr_reg <= '0;
    end else if (upd && ex_branch) begin
      ctr_reg[ex_pred_idx] <= ctr_next;
      ghr_reg              <= ghr_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BTB_N; i++) begin
        btb_valid_reg[i]  <= 1'b0;
        btb_jump_reg[i]   <= 1'b0;
        btb_tag_reg[i]    <= '0;
        btb_target_reg[i] <= '0;
      end
    end else if (upd && ex_taken) begin
      btb_valid_reg[ex_slot]  <= 1'b1;
      btb_jump_reg[ex_slot]   <= ex_jump;
      btb_tag_reg[ex_slot]    <= ex_pc[31:BTB_IDX+2];
      btb_target_reg[ex_slot] <= ex_target;
    end else if (stale) begin
      btb_valid_reg[ex_slot] <= 1'b0;
    end
  end

endmodule
